// File: rtl/multiff_sched.sv
`default_nettype none
// ============================================================================
// Module   : multiff_sched
// Purpose  : Round-robin write scheduler for the multi-channel register bank
//            (multiff). It arbitrates CHANNELS requesters onto the bank's
//            single write port. It sets up inlines/channel before a
//            glitch-free, registered load strobe. It also keeps a
//            reset-cleared shadow copy of every channel's last written word.
// Ports    : clk      - system clock, rising edge
//            rst_n    - synchronous active-low reset
//            req      - per-channel write request (level)
//            wdata    - per-channel write word, channel i at [i*BUSWIDTH +: BUSWIDTH]
//            ack      - one-cycle, one-hot write-complete pulse
//            inlines  - bank data input
//            channel  - bank channel select
//            load     - bank load strobe
//            busy     - high whenever the scheduler is not idle
//            shadow   - mirror of the last value written to each channel
// Revision : 1.0 - initial release
// ============================================================================
module multiff_sched #(
    parameter int BUSWIDTH      = 8,
    parameter int CHANNELS      = 4,
    parameter int CHANNELBITS   = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*BUSWIDTH-1:0] wdata,
    output logic [CHANNELS-1:0]          ack,
    output logic [BUSWIDTH-1:0]          inlines,
    output logic [CHANNELBITS-1:0]       channel,
    output logic                         load,
    output logic                         busy,
    output logic [CHANNELS*BUSWIDTH-1:0] shadow
);

    // One counter serves both timed states, so it is sized for the longer one.
    localparam int c_max_cycles = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;
    localparam logic [c_cnt_w-1:0] c_setup_last  = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(STROBE_CYCLES - 1);
    localparam logic [CHANNELBITS-1:0] c_last_ch = CHANNELBITS'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                         state_q;
    logic [c_cnt_w-1:0]             cnt_q;
    logic [CHANNELBITS-1:0]         rr_q;
    logic [CHANNELBITS-1:0]         chan_q;
    logic [BUSWIDTH-1:0]            inlines_q;
    logic                           load_q;
    logic                           busy_q;
    logic [CHANNELS-1:0]            ack_q;
    logic [CHANNELS*BUSWIDTH-1:0]   shadow_q;

    // Grant candidate for the next IDLE cycle.
    logic                           gnt_vld_d;
    logic [CHANNELBITS-1:0]         gnt_d;
    logic [BUSWIDTH-1:0]            gnt_data_d;

    // Round-robin search: first set request at or above the pointer,
    // wrapping at CHANNELS (which need not be a power of two).
    always_comb begin
        int idx;
        gnt_vld_d  = 1'b0;
        gnt_d      = '0;
        gnt_data_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!gnt_vld_d && req[idx]) begin
                gnt_vld_d  = 1'b1;
                gnt_d      = CHANNELBITS'(idx);
                gnt_data_d = wdata[idx*BUSWIDTH +: BUSWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rr_q      <= '0;
            chan_q    <= '0;
            inlines_q <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            shadow_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (gnt_vld_d) begin
                        // Data is captured here; later req/wdata changes are ignored.
                        inlines_q <= gnt_data_d;
                        chan_q    <= gnt_d;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == c_setup_last) begin
                        load_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_STROBE;
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (chan_q == CHANNELBITS'(i)) begin
                                shadow_q[i*BUSWIDTH +: BUSWIDTH] <= inlines_q;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == c_strobe_last) begin
                        load_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                        for (int i = 0; i < CHANNELS; i++) begin
                            ack_q[i] <= (chan_q == CHANNELBITS'(i));
                        end
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                ST_HOLD: begin
                    // inlines/channel stay put one more cycle after load falls.
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    rr_q    <= (chan_q == c_last_ch) ? '0 : chan_q + CHANNELBITS'(1);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ack_q   <= '0;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign inlines = inlines_q;
    assign channel = chan_q;
    assign load    = load_q;
    assign busy    = busy_q;
    assign shadow  = shadow_q;

endmodule
`default_nettype wire
